// File: rtl/fp32_mul_pkg.sv
// Shared types, field widths and operand classification for the fp32 multiply sequencer.
package fp32_mul_pkg;

    localparam int          EXP_W = 8;
    localparam int          MAN_W = 23;
    localparam int          BIAS  = 127;
    localparam logic [31:0] QNAN  = 32'h7FC00000;

    typedef enum logic [2:0] {
        IDLE,
        CHECK,
        MUL,
        NORM,
        DONE
    } state_t;

    typedef enum logic [1:0] {
        CLS_ZERO,
        CLS_NORM,
        CLS_INF,
        CLS_NAN
    } fp_class_t;

    typedef struct packed {
        logic nan;
        logic overflow;
        logic underflow;
    } fp_flags_t;

    // Denormals classify as zero: they are flushed before any arithmetic.
    function automatic fp_class_t fp_classify(input logic [31:0] x);
        logic [EXP_W-1:0] e;
        logic [MAN_W-1:0] f;
        e = x[30:23];
        f = x[22:0];
        if (e == '1) begin
            return (f != '0) ? CLS_NAN : CLS_INF;
        end else if (e == '0) begin
            return CLS_ZERO;
        end
        return CLS_NORM;
    endfunction

endpackage

// File: rtl/fp32_mul_sequencer_if.sv
// Operand/result valid-ready bus of the fp32 multiply sequencer.
interface fp32_mul_sequencer_if;
    import fp32_mul_pkg::*;

    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_res;
    fp_flags_t   out_flags;

    modport master (
        output in_valid, in_a, in_b, out_ready,
        input  in_ready, out_valid, out_res, out_flags
    );

    modport slave (
        input  in_valid, in_a, in_b, out_ready,
        output in_ready, out_valid, out_res, out_flags
    );

endinterface

// File: rtl/fp32_mul_sequencer_mant_mul_iter.sv
// Iterative 24x24 shift-add mantissa multiplier retiring BITS_PER_CYC multiplier bits per cycle.
module mant_mul_iter #(
    parameter int BITS_PER_CYC = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [23:0] mcand,
    input  logic [23:0] mplier,
    output logic        busy,
    output logic        done,
    output logic [47:0] product
);
    localparam int ITER  = 24 / BITS_PER_CYC;
    localparam int CNT_W = $clog2(ITER + 1);
    localparam int SUM_W = 24 + BITS_PER_CYC;

    logic [23:0]      mcand_reg;
    logic [47:0]      acc_reg;
    logic [47:0]      acc_next;
    logic [CNT_W-1:0] cnt_reg;
    logic             busy_reg;
    logic [SUM_W-1:0] pp [BITS_PER_CYC];
    logic [SUM_W-1:0] hi_sum;

    // acc low half holds the not-yet-consumed multiplier bits; the high half accumulates.
    generate
        for (genvar gi = 0; gi < BITS_PER_CYC; gi++) begin : g_pp
            assign pp[gi] = acc_reg[gi] ? ({{BITS_PER_CYC{1'b0}}, mcand_reg} << gi) : '0;
        end
    endgenerate

    always_comb begin
        hi_sum = {{BITS_PER_CYC{1'b0}}, acc_reg[47:24]};
        for (int i = 0; i < BITS_PER_CYC; i++) begin
            hi_sum = hi_sum + pp[i];
        end
    end

    assign acc_next = 48'({hi_sum, acc_reg[23:0]} >> BITS_PER_CYC);
    assign done     = busy_reg && (cnt_reg == CNT_W'(ITER - 1));
    assign busy     = busy_reg;
    assign product  = acc_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            mcand_reg <= '0;
            acc_reg   <= '0;
            cnt_reg   <= '0;
            busy_reg  <= 1'b0;
        end else if (start) begin
            mcand_reg <= mcand;
            acc_reg   <= {24'b0, mplier};
            cnt_reg   <= '0;
            busy_reg  <= 1'b1;
        end else if (busy_reg) begin
            acc_reg <= acc_next;
            if (done) begin
                busy_reg <= 1'b0;
            end else begin
                cnt_reg <= cnt_reg + 1'b1;
            end
        end
    end

endmodule

// File: rtl/fp32_mul_sequencer.sv
// fp32 multiply sequencer: FSM, unpack, special cases, exponent path, normalise, round, pack.
// Define FP_MUL_RNE_EN for round-to-nearest-even; otherwise results are truncated.
module fp32_mul_sequencer
    import fp32_mul_pkg::*;
#(
    parameter int BITS_PER_CYC = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    fp32_mul_sequencer_if.slave  bus
);

    state_t            state_reg, state_next;
    logic [31:0]       a_reg, b_reg;
    logic              sign_reg;
    logic signed [9:0] exp_reg;
    logic [31:0]       res_reg, res_next;
    fp_flags_t         flags_reg, flags_next;

    fp_class_t         cls_a, cls_b;
    logic              sign_ab;
    logic              is_special;
    logic [31:0]       special_res;
    fp_flags_t         special_flags;
    logic signed [9:0] exp_sum;

    logic              mul_start, mul_busy, mul_done;
    logic [47:0]       mul_product;

    logic [22:0]       frac_pre, frac_fin;
    logic signed [9:0] exp_pre, exp_fin;
    logic              round_inc;
    logic [24:0]       mant_rnd;
    logic [31:0]       norm_res;
    fp_flags_t         norm_flags;
    logic              unused_bits;
`ifdef FP_MUL_RNE_EN
    logic              guard, sticky;
`endif

    assign cls_a      = fp_classify(a_reg);
    assign cls_b      = fp_classify(b_reg);
    assign sign_ab    = a_reg[31] ^ b_reg[31];
    assign is_special = (cls_a != CLS_NORM) || (cls_b != CLS_NORM);
    assign exp_sum    = $signed({2'b00, a_reg[30:23]}) + $signed({2'b00, b_reg[30:23]})
                      - 10'sd127;

    always_comb begin
        special_res   = {sign_ab, 31'b0};
        special_flags = '0;
        if (cls_a == CLS_NAN || cls_b == CLS_NAN ||
            (cls_a == CLS_INF && cls_b == CLS_ZERO) ||
            (cls_a == CLS_ZERO && cls_b == CLS_INF)) begin
            special_res       = QNAN;
            special_flags.nan = 1'b1;
        end else if (cls_a == CLS_INF || cls_b == CLS_INF) begin
            special_res = {sign_ab, 8'hFF, 23'b0};
        end
    end

    mant_mul_iter #(
        .BITS_PER_CYC (BITS_PER_CYC)
    ) u_mant_mul_iter (
        .clk     (clk),
        .rst     (rst),
        .start   (mul_start),
        .mcand   ({1'b1, a_reg[22:0]}),
        .mplier  ({1'b1, b_reg[22:0]}),
        .busy    (mul_busy),
        .done    (mul_done),
        .product (mul_product)
    );

    // The product of two [1,2) mantissas lies in [1,4): at most one right shift normalises it.
    always_comb begin
        if (mul_product[47]) begin
            frac_pre = mul_product[46:24];
            exp_pre  = exp_reg + 10'sd1;
        end else begin
            frac_pre = mul_product[45:23];
            exp_pre  = exp_reg;
        end
`ifdef FP_MUL_RNE_EN
        guard     = mul_product[47] ? mul_product[23] : mul_product[22];
        sticky    = mul_product[47] ? (|mul_product[22:0]) : (|mul_product[21:0]);
        round_inc = guard & (sticky | frac_pre[0]);
`else
        round_inc = 1'b0;
`endif
    end

`ifdef FP_MUL_RNE_EN
    assign unused_bits = mul_busy;
`else
    assign unused_bits = ^{mul_busy, mul_product[22:0]};
`endif

    always_comb begin
        mant_rnd   = {2'b01, frac_pre} + {24'b0, round_inc};
        frac_fin   = mant_rnd[24] ? mant_rnd[23:1] : mant_rnd[22:0];
        exp_fin    = mant_rnd[24] ? exp_pre + 10'sd1 : exp_pre;
        norm_res   = {sign_reg, exp_fin[7:0], frac_fin};
        norm_flags = '0;
        if (exp_fin >= 10'sd255) begin
            norm_res            = {sign_reg, 8'hFF, 23'b0};
            norm_flags.overflow = 1'b1;
        end else if (exp_fin <= 10'sd0) begin
            norm_res             = {sign_reg, 31'b0};
            norm_flags.underflow = 1'b1;
        end
    end

    always_comb begin
        state_next = state_reg;
        mul_start  = 1'b0;
        res_next   = res_reg;
        flags_next = flags_reg;
        unique case (state_reg)
            IDLE: begin
                if (bus.in_valid) state_next = CHECK;
            end
            CHECK: begin
                if (is_special) begin
                    state_next = DONE;
                    res_next   = special_res;
                    flags_next = special_flags;
                end else begin
                    state_next = MUL;
                    mul_start  = 1'b1;
                end
            end
            MUL: begin
                if (mul_done) state_next = NORM;
            end
            NORM: begin
                state_next = DONE;
                res_next   = norm_res;
                flags_next = norm_flags;
            end
            DONE: begin
                if (bus.out_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            a_reg     <= '0;
            b_reg     <= '0;
            sign_reg  <= 1'b0;
            exp_reg   <= '0;
            res_reg   <= '0;
            flags_reg <= '0;
        end else begin
            state_reg <= state_next;
            res_reg   <= res_next;
            flags_reg <= flags_next;
            if (state_reg == IDLE && bus.in_valid) begin
                a_reg <= bus.in_a;
                b_reg <= bus.in_b;
            end
            if (state_reg == CHECK) begin
                sign_reg <= sign_ab;
                exp_reg  <= exp_sum;
            end
        end
    end

    assign bus.in_ready  = (state_reg == IDLE);
    assign bus.out_valid = (state_reg == DONE);
    assign bus.out_res   = res_reg;
    assign bus.out_flags = flags_reg;

endmodule
